hilo_muldiv_ctrl: RTL and testbench

//  Initiator side of the iterative divider handshake, plus the HI/LO register file for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/hilo_muldiv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with an internal shift-add multiplier and the
// initiator side of a start/done handshake to an external divider.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic             div_signed,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV_REQ,
    S_DIV_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_start_q, div_start_d;
  logic               div_signed_q, div_signed_d;
  logic [WIDTH-1:0]   div_a_q, div_a_d;
  logic [WIDTH-1:0]   div_b_q, div_b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] sum;
  logic               is_mult;

  // Magnitudes are treated as unsigned, so |0x80000000| stays 0x80000000.
  assign abs_a   = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign abs_b   = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
  assign is_mult = (op == OP_MULT);
  assign sum     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_start_d  = div_start_q;
    div_signed_d = div_signed_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
              mcand_d  = {{WIDTH{1'b0}}, is_mult ? abs_a : a};
              mplier_d = is_mult ? abs_b : b;
              neg_d    = is_mult & (a[WIDTH-1] ^ b[WIDTH-1]);
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (b != '0) begin
                div_a_d      = a;
                div_b_d      = b;
                div_signed_d = (op == OP_DIV);
                div_start_d  = 1'b1;
                state_d      = S_DIV_REQ;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          {hi_d, lo_d} = neg_q ? ({(2*WIDTH){1'b0}} - sum) : sum;
          state_d      = S_IDLE;
        end
      end
      // The divider is restarting here, so a done seen now is stale.
      S_DIV_REQ: begin
        div_start_d = 1'b0;
        state_d     = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          lo_d    = div_q;
          hi_d    = div_r;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign div_start  = div_start_q;
  assign div_signed = div_signed_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed vector table, reset corner
// sequences and random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  logic        div_start, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_done;
  logic [31:0] div_q, div_r;

  int checks = 0;
  int failures = 0;

  int div_lat = 5;
  bit stale_en = 1'b0;
  int junk_mode = 0;

  logic        done_m;
  logic [31:0] q_m, r_m;
  int          dly;

  logic [31:0] mh, ml;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo),
    .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_done(div_done),
    .div_q(div_q), .div_r(div_r)
  );

  function automatic logic [31:0] fdiv(bit s, logic [31:0] x, logic [31:0] y, bit rem);
    int sx, sy;
    if (y == 32'h0) return 32'h0;
    sx = $signed(x);
    sy = $signed(y);
    if (s) return rem ? 32'(sx % sy) : 32'(sx / sy);
    return rem ? (x % y) : (x / y);
  endfunction

  // Divider stand-in: done pulses div_lat edges after start was seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dly <= 0;
      done_m <= 1'b0;
      q_m <= 32'h0;
      r_m <= 32'h0;
    end else begin
      done_m <= 1'b0;
      if (div_start) dly <= div_lat;
      else if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          done_m <= 1'b1;
          q_m <= fdiv(div_signed, div_a, div_b, 1'b0);
          r_m <= fdiv(div_signed, div_a, div_b, 1'b1);
        end
      end
    end
  end

  assign div_done = done_m | (stale_en & div_start);
  assign div_q = stale_en && div_start ? 32'hDEAD0001 : q_m;
  assign div_r = stale_en && div_start ? 32'hDEAD0002 : r_m;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_op(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd1: begin p = 64'(sx * sy); {mh, ml} = p; end
      3'd2: begin p = {32'h0, x} * {32'h0, y}; {mh, ml} = p; end
      3'd3: if (y != 0) begin ml = fdiv(1'b1, x, y, 1'b0); mh = fdiv(1'b1, x, y, 1'b1); end
      3'd4: if (y != 0) begin ml = x / y; mh = x % y; end
      3'd5: mh = x;
      3'd6: ml = x;
      default: ;
    endcase
  endtask

  function automatic int exp_cyc(logic [2:0] o, logic [31:0] y);
    if (o == 3'd1 || o == 3'd2) return 32;
    if ((o == 3'd3 || o == 3'd4) && y != 0) return div_lat + 2;
    return 0;
  endfunction

  function automatic int exp_starts(logic [2:0] o, logic [31:0] y);
    return ((o == 3'd3 || o == 3'd4) && y != 0) ? 1 : 0;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output int starts, output bit hold_ok, output bit opnd_ok);
    logic [31:0] h0, l0;
    bit is_div;
    is_div = (o == 3'd3 || o == 3'd4) && y != 0;
    @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    h0 = hi; l0 = lo;
    cyc = 0; starts = 0; hold_ok = 1'b1; opnd_ok = 1'b1;
    while (busy && cyc < 200) begin
      cyc++;
      if (div_start) starts++;
      if (is_div && (div_a !== x || div_b !== y || div_signed !== (o == 3'd3)))
        opnd_ok = 1'b0;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (junk_mode == 1) begin
        op_valid = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom;
      end else if (junk_mode == 2) begin
        op_valid = 1'b1; op = 3'd6; a = 32'h00000AAA;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    op = 3'd0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vt[11];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, starts;
    bit hold_ok, opnd_ok;
    logic [2:0] o;
    logic [31:0] x, y;

    vt[0]  = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 32};
    vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32};
    vt[2]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32};
    vt[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 7};
    vt[4]  = '{3'd5, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFD, 0};
    vt[5]  = '{3'd6, 32'h00005678, 32'h0, 32'h00001234, 32'h00005678, 0};
    vt[6]  = '{3'd4, 32'h00000099, 32'h0, 32'h00001234, 32'h00005678, 0};
    vt[7]  = '{3'd2, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 32};
    vt[8]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 7};
    vt[9]  = '{3'd0, 32'h11111111, 32'h2, 32'h00000002, 32'h0000000E, 0};
    vt[10] = '{3'd7, 32'h22222222, 32'h3, 32'h00000002, 32'h0000000E, 0};

    reset = 1'b1; op_valid = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    mh = 32'h0; ml = 32'h0;
    #12;
    check32("rst_hi", hi, 32'h0);
    check32("rst_lo", lo, 32'h0);
    check32("rst_busy", {31'h0, busy}, 32'h0);
    check32("rst_div_start", {31'h0, div_start}, 32'h0);
    check32("rst_div_signed", {31'h0, div_signed}, 32'h0);
    check32("rst_div_a", div_a, 32'h0);
    check32("rst_div_b", div_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    div_lat = 5;
    junk_mode = 1;
    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, cyc, starts, hold_ok, opnd_ok);
      check32($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      check32($sformatf("vec%0d_lo", i), lo, vt[i].lo);
      check_int($sformatf("vec%0d_busy_cycles", i), cyc, vt[i].cyc);
      check_int($sformatf("vec%0d_starts", i), starts, exp_starts(vt[i].op, vt[i].b));
      check_int($sformatf("vec%0d_hold", i), int'(hold_ok), 1);
      check_int($sformatf("vec%0d_operands", i), int'(opnd_ok), 1);
    end
    mh = hi; ml = lo;
    mh = vt[10].hi; ml = vt[10].lo;

    // MTLO presented on every MUL cycle must be dropped
    junk_mode = 2;
    model_op(3'd1, 32'h00012345, 32'hFFF6789A);
    do_op(3'd1, 32'h00012345, 32'hFFF6789A, cyc, starts, hold_ok, opnd_ok);
    check32("mtlo_in_mul_lo", lo, ml);
    check32("mtlo_in_mul_hi", hi, mh);
    check_int("mtlo_in_mul_cycles", cyc, 32);
    junk_mode = 0;

    // stale done during the start cycle must not complete the op
    stale_en = 1'b1;
    div_lat = 3;
    model_op(3'd3, 32'h7FFFFFF0, 32'hFFFFFFF3);
    do_op(3'd3, 32'h7FFFFFF0, 32'hFFFFFFF3, cyc, starts, hold_ok, opnd_ok);
    check32("stale_done_hi", hi, mh);
    check32("stale_done_lo", lo, ml);
    check_int("stale_done_cycles", cyc, exp_cyc(3'd3, 32'hFFFFFFF3));
    stale_en = 1'b0;

    // reset mid-MUL, 10 cycles in
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; a = 32'h00000005; b = 32'h00000007;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check32("mid_mul_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check32("mul_rst_busy", {31'h0, busy}, 32'h0);
    check32("mul_rst_hi", hi, 32'h0);
    check32("mul_rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mh = 32'h0; ml = 32'h0;
    model_op(3'd1, 32'hFFFFFFFD, 32'h00000007);
    do_op(3'd1, 32'hFFFFFFFD, 32'h00000007, cyc, starts, hold_ok, opnd_ok);
    check32("post_rst_mul_hi", hi, mh);
    check32("post_rst_mul_lo", lo, ml);

    // reset while div_start is high drops it at once
    div_lat = 5;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; a = 32'h00000100; b = 32'h00000003;
    @(negedge clk);
    op_valid = 1'b0;
    check32("req_div_start", {31'h0, div_start}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check32("req_rst_div_start", {31'h0, div_start}, 32'h0);
    check32("req_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mh = 32'h0; ml = 32'h0;

    // reset in DIV_WAIT discards the pending result
    model_op(3'd5, 32'hCAFE0001, 32'h0);
    do_op(3'd5, 32'hCAFE0001, 32'h0, cyc, starts, hold_ok, opnd_ok);
    model_op(3'd6, 32'hCAFE0002, 32'h0);
    do_op(3'd6, 32'hCAFE0002, 32'h0, cyc, starts, hold_ok, opnd_ok);
    div_lat = 20;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; a = 32'h00000064; b = 32'h00000007;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    check32("wait_busy", {31'h0, busy}, 32'h1);
    check32("wait_div_start", {31'h0, div_start}, 32'h0);
    check32("wait_hi_held", hi, 32'hCAFE0001);
    #2 reset = 1'b1;
    #1;
    check32("wait_rst_busy", {31'h0, busy}, 32'h0);
    check32("wait_rst_hi", hi, 32'h0);
    check32("wait_rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mh = 32'h0; ml = 32'h0;
    repeat (25) @(negedge clk);
    check32("wait_discard_lo", lo, 32'h0);
    model_op(3'd2, 32'hFFFFFFFF, 32'h00000003);
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000003, cyc, starts, hold_ok, opnd_ok);
    check32("post_wait_mul_hi", hi, mh);
    check32("post_wait_mul_lo", lo, ml);

    // random ops against the model
    junk_mode = 1;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (o == 3'd3 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'h1;
      div_lat = $urandom_range(1, 6);
      stale_en = 1'($urandom_range(0, 1));
      model_op(o, x, y);
      do_op(o, x, y, cyc, starts, hold_ok, opnd_ok);
      check32($sformatf("rand%0d_op%0d_hi", i, o), hi, mh);
      check32($sformatf("rand%0d_op%0d_lo", i, o), lo, ml);
      check_int($sformatf("rand%0d_op%0d_cycles", i, o), cyc, exp_cyc(o, y));
      check_int($sformatf("rand%0d_op%0d_starts", i, o), starts, exp_starts(o, y));
      check_int($sformatf("rand%0d_op%0d_hold", i, o), int'(hold_ok), 1);
      check_int($sformatf("rand%0d_op%0d_operands", i, o), int'(opnd_ok), 1);
    end
    stale_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
